dm_responder: RTL and testbench
===============================

Name: dm_responder

Overview:
- Memory-stage data memory: the responder side of the M-stage MemWrite/MemRead control.
- Accepts one load or store per request and holds the pipeline with Stall for a fixed, parameterised latency.
- Performs byte/half/word stores with merge. Performs loads with sign or zero extension.
- Flags misaligned or out-of-range accesses.
- Sits between the M-stage pipeline register and the W-stage register.

Parameters:
- DEPTH, 1024, number of 32-bit words; power of two.
- LAT, 2, access latency in cycles; legal range 1..15.
- ADDR_BASE, 32'h0000_0000, byte address of word 0; must be DEPTH*4 aligned.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- MemWrite  input  1  store request.
- MemRead  input  1  load request.
- Op  input  6  M-stage opcode; selects access width and extension.
- Addr  input  32  byte address.
- WData  input  32  store data; low bits are used for sb/sh.
- PC  input  32  M-stage PC; used only by the optional log.
- RData  output  32  extended load result, registered.
- Stall  output  1  hold the pipeline; upstream keeps all inputs stable while it is 1.
- AddrErr  output  1  one-cycle pulse on a faulting access.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE, cnt=0, RData=0, AddrErr=0, all memory words=0.
  - Stall=0 while reset is high.
- Opcodes:
  - lw 100011, lh 100001, lhu 100101, lb 100000, lbu 100100.
  - sw 101011, sh 101001, sb 101000.
  - Any other Op with a request is treated as a word access.
- Request: req = MemWrite | MemRead. If both are high, the access is a store; the read is ignored.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: Stall = req, combinationally. If req at the edge: latch Op, Addr, WData, PC and the write flag; load cnt=LAT-1; go to BUSY.
  - BUSY: Stall=1. If cnt==0, go to DONE; else decrement cnt.
  - DONE: Stall=0. Store commits at the DONE->IDLE edge. RData/AddrErr are valid this cycle. Next state is IDLE.
  - A request visible at cycle 0 has Stall=1 for cycles 0..LAT and DONE at cycle LAT+1.
  - DONE->IDLE always inserts one cycle before the next accept.
- Addressing:
  - Offset = Addr - ADDR_BASE; word index = offset[31:2].
  - Out of range when offset >= DEPTH*4, including offsets that wrap below ADDR_BASE.
  - Little-endian: byte lane k occupies bits 8k+7:8k, where k = Addr[1:0].
- Stores:
  - sw writes the full word.
  - sh writes the halfword at Addr[1]; sb writes the byte at Addr[1:0].
  - Other lanes are preserved (read-merge-write of the stored word).
- Loads:
  - Source word is read at the BUSY->DONE edge.
  - Lane is extracted; lb/lh sign-extend, lbu/lhu zero-extend.
  - RData is registered at that edge and held until the next DONE.
- Faults:
  - Misaligned: word ops with Addr[1:0]!=0; half ops with Addr[0]!=0.
  - Out of range, as defined above.
  - On fault: AddrErr=1 for the DONE cycle only, no memory change, RData=0.
- Reset mid-operation (during BUSY or DONE): FSM returns to IDLE, the pending store is discarded, outputs take reset values.
- Changing inputs while Stall=1 has no effect, because the request is latched at accept.

Optional Feature:
- Macro: DM_WRITE_LOG_EN.
- Defined: on every committed store (not faulted), at the commit edge, $display("@%h: *%h <= %h", PC, word-aligned byte address, merged 32-bit word).
- Undefined: no display logic is compiled in; functional behaviour is identical.

Test Plan:
- Reset held 1 cycle, then idle for 3 cycles -> Stall=0, RData=0, AddrErr=0; lw from 0x0 gives RData=0x00000000.
- LAT=2: sw 0x12345678 to 0x10 at cycle 0 -> Stall=1 on cycles 0,1,2 and 0 on cycle 3. A following lw 0x10 -> RData=0x12345678.
- After word 0x10 = 0x12345678: sb WData=0xAB to 0x11 -> word becomes 0x1234AB78. lb 0x11 -> 0xFFFFFFAB; lbu 0x11 -> 0x000000AB; lh 0x12 -> 0x00001234.
- sh to 0x13 -> AddrErr=1 for exactly the DONE cycle, memory unchanged. lw to DEPTH*4 -> AddrErr=1, RData=0.
- MemWrite=MemRead=1 with sw 0xCAFEF00D to 0x20 -> store performed. Reset asserted during BUSY of a later sw 0xDEADBEEF to 0x24 -> FSM goes to IDLE, word 0x24 stays 0.
- With DM_WRITE_LOG_EN, PC=0x3000 and sh 0xBEEF to 0x42 over a word that was 0 -> prints "@00003000: *00000040 <= beef0000". Without the macro -> no output.

Source files
------------

// File: rtl/dm_responder.sv
// Memory-stage data memory responder: fixed-latency load/store with lane merge,
// load extension and fault flagging. Optional store log under DM_WRITE_LOG_EN.
module dm_responder #(
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned LAT       = 2,
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [5:0]  Op,
    input  logic [31:0] Addr,
    input  logic [31:0] WData,
    input  logic [31:0] PC,
    output logic [31:0] RData,
    output logic        Stall,
    output logic        AddrErr
);

    localparam int unsigned AW = $clog2(DEPTH);

    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SB  = 6'b101000;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [5:0]  op_q;
    logic [31:0] addr_q, wdata_q, pc_q;
    logic        wr_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic [31:0] mem_q [DEPTH];
    logic [DEPTH-1:0] valid_q;

    logic        req;
    logic [31:0] off;
    logic [AW-1:0] idx;
    logic        oor, is_b, is_h, sgn, fault;
    logic [31:0] word, shifted, load_v, mask, wdat, merged;

    assign req     = MemWrite | MemRead;
    assign off     = addr_q - ADDR_BASE;
    assign idx     = off[AW+1:2];
    assign oor     = (off >> (AW + 2)) != '0;
    assign is_b    = (op_q == OP_LB) || (op_q == OP_LBU) || (op_q == OP_SB);
    assign is_h    = (op_q == OP_LH) || (op_q == OP_LHU) || (op_q == OP_SH);
    assign sgn     = (op_q == OP_LB) || (op_q == OP_LH);
    assign fault   = oor | (is_h & addr_q[0]) | (~is_b & ~is_h & (addr_q[1:0] != 2'b00));
    // Reset clears a per-word valid bit rather than the array, so unwritten words read as zero.
    assign word    = valid_q[idx] ? mem_q[idx] : '0;
    assign shifted = word >> {addr_q[1:0], 3'b000};

    always_comb begin
        load_v = word;
        mask   = '1;
        wdat   = wdata_q;
        if (is_b) begin
            load_v = sgn ? {{24{shifted[7]}}, shifted[7:0]} : {24'b0, shifted[7:0]};
            mask   = 32'h0000_00FF << {addr_q[1:0], 3'b000};
            wdat   = {4{wdata_q[7:0]}};
        end else if (is_h) begin
            load_v = sgn ? {{16{shifted[15]}}, shifted[15:0]} : {16'b0, shifted[15:0]};
            mask   = 32'h0000_FFFF << {addr_q[1], 4'b0000};
            wdat   = {2{wdata_q[15:0]}};
        end
        merged = (word & ~mask) | (wdat & mask);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        Stall   = 1'b0;
        case (state_q)
            IDLE: begin
                Stall = req;
                if (req) begin
                    state_d = BUSY;
                    cnt_d   = 4'(LAT - 1);
                end
            end
            BUSY: begin
                Stall = 1'b1;
                if (cnt_q == '0) state_d = DONE;
                else             cnt_d   = cnt_q - 4'd1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (reset) Stall = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            valid_q <= '0;
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            pc_q    <= '0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= 1'b0;
            if (state_q == IDLE && req) begin
                op_q    <= Op;
                addr_q  <= Addr;
                wdata_q <= WData;
                pc_q    <= PC;
                wr_q    <= MemWrite;
            end
            if (state_q == BUSY && cnt_q == '0) begin
                err_q <= fault;
                if (fault)      rdata_q <= '0;
                else if (!wr_q) rdata_q <= load_v;
            end
            if (state_q == DONE && wr_q && !err_q) valid_q[idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && state_q == DONE && wr_q && !err_q) mem_q[idx] <= merged;
    end

`ifdef DM_WRITE_LOG_EN
    always_ff @(posedge clk) begin
        if (!reset && state_q == DONE && wr_q && !err_q)
            $display("@%h: *%h <= %h", pc_q, {addr_q[31:2], 2'b00}, merged);
    end
`else
    logic unused_pc;
    assign unused_pc = ^pc_q;
`endif

    assign RData   = rdata_q;
    assign AddrErr = err_q;

endmodule

// File: tb/tb_dm_responder.sv
// Self-checking bench for dm_responder: directed plan steps plus random accesses
// compared against a byte-addressed reference memory.
module tb_dm_responder;

    localparam int unsigned DEPTH = 1024;
    localparam int unsigned LAT   = 2;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    localparam logic [5:0] LW = 6'b100011, LH = 6'b100001, LHU = 6'b100101;
    localparam logic [5:0] LB = 6'b100000, LBU = 6'b100100;
    localparam logic [5:0] SW = 6'b101011, SH = 6'b101001, SB = 6'b101000;

    logic        clk = 1'b0;
    logic        reset, MemWrite, MemRead;
    logic [5:0]  Op;
    logic [31:0] Addr, WData, PC, RData;
    logic        Stall, AddrErr;

    int tests = 0;
    int fails = 0;

    logic [7:0]  mdl [DEPTH*4];
    logic [31:0] exp_rd;
    logic [5:0]  ops [8];

    dm_responder #(.DEPTH(DEPTH), .LAT(LAT), .ADDR_BASE(BASE)) dut (
        .clk(clk), .reset(reset), .MemWrite(MemWrite), .MemRead(MemRead),
        .Op(Op), .Addr(Addr), .WData(WData), .PC(PC),
        .RData(RData), .Stall(Stall), .AddrErr(AddrErr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned op_size(input logic [5:0] op);
        if (op == LB || op == LBU || op == SB) return 1;
        if (op == LH || op == LHU || op == SH) return 2;
        return 4;
    endfunction

    task automatic model_clear();
        foreach (mdl[i]) mdl[i] = 8'h00;
        exp_rd = '0;
    endtask

    // Byte-level view of the memory: stores write bytes, loads gather bytes.
    task automatic model(input logic wr, input logic [5:0] op, input logic [31:0] addr,
                         input logic [31:0] wd, output logic err);
        int unsigned sz;
        logic [31:0] off, v;
        sz  = op_size(op);
        off = addr - BASE;
        err = (off >= 32'(DEPTH * 4)) || ((addr % sz) != 0);
        if (err) begin
            exp_rd = '0;
        end else if (wr) begin
            for (int unsigned i = 0; i < sz; i++) mdl[off + i] = wd[8*i +: 8];
        end else begin
            v = '0;
            for (int unsigned i = 0; i < sz; i++) v = v | (32'(mdl[off + i]) << (8 * i));
            if (op == LB && v[7])  v = v | 32'hFFFF_FF00;
            if (op == LH && v[15]) v = v | 32'hFFFF_0000;
            exp_rd = v;
        end
    endtask

    task automatic access(input logic wr, input logic rd, input logic [5:0] op,
                          input logic [31:0] addr, input logic [31:0] wd, input string tag);
        logic err;
        @(posedge clk); #1;
        MemWrite = wr; MemRead = rd; Op = op; Addr = addr; WData = wd; PC = $urandom;
        model(wr, op, addr, wd, err);
        for (int c = 0; c <= int'(LAT); c++) begin
            @(negedge clk);
            check({tag, " stall"}, 32'(Stall), 32'd1);
            check({tag, " busy_err"}, 32'(AddrErr), 32'd0);
            @(posedge clk); #1;
            Addr = $urandom; WData = $urandom; Op = 6'($urandom); MemWrite = 1'($urandom);
        end
        @(negedge clk);
        check({tag, " done_stall"}, 32'(Stall), 32'd0);
        check({tag, " err"}, 32'(AddrErr), 32'(err));
        if (err || !wr) check({tag, " rdata"}, RData, exp_rd);
        MemWrite = 1'b0; MemRead = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check({tag, " err_pulse"}, 32'(AddrErr), 32'd0);
        check({tag, " idle_stall"}, 32'(Stall), 32'd0);
    endtask

    initial begin
        ops = '{LW, LH, LHU, LB, LBU, SW, SH, SB};
        reset = 1'b1; MemWrite = 1'b0; MemRead = 1'b1; Op = LW; Addr = '0; WData = '0; PC = '0;
        model_clear();
        @(negedge clk);
        check("stall_in_reset", 32'(Stall), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0; MemRead = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_stall", 32'(Stall), 32'd0);
            check("rst_rdata", RData, 32'd0);
            check("rst_err", 32'(AddrErr), 32'd0);
        end

        access(0, 1, LW, 32'h0, 32'h0, "lw0");
        check("lw0_const", RData, 32'h0000_0000);
        access(1, 0, SW, 32'h10, 32'h1234_5678, "sw10");
        access(0, 1, LW, 32'h10, 32'h0, "lw10");
        check("lw10_const", RData, 32'h1234_5678);
        access(1, 0, SB, 32'h11, 32'h0000_00AB, "sb11");
        access(0, 1, LW, 32'h10, 32'h0, "lw10m");
        check("merge_const", RData, 32'h1234_AB78);
        access(0, 1, LB, 32'h11, 32'h0, "lb11");
        check("lb_const", RData, 32'hFFFF_FFAB);
        access(0, 1, LBU, 32'h11, 32'h0, "lbu11");
        check("lbu_const", RData, 32'h0000_00AB);
        access(0, 1, LH, 32'h12, 32'h0, "lh12");
        check("lh_const", RData, 32'h0000_1234);
        access(1, 0, SH, 32'h13, 32'h0000_5555, "sh13_mis");
        access(0, 1, LW, 32'h10, 32'h0, "lw10_keep");
        check("mis_nochange", RData, 32'h1234_AB78);
        access(0, 1, LW, 32'(DEPTH * 4), 32'h0, "lw_oor");
        check("oor_rdata", RData, 32'h0);
        access(0, 1, LW, 32'hFFFF_FFFC, 32'h0, "lw_wrap");
        access(1, 1, SW, 32'h20, 32'hCAFE_F00D, "swrd20");
        access(0, 1, LW, 32'h20, 32'h0, "lw20");
        check("both_store", RData, 32'hCAFE_F00D);

        // Abort a store with reset while the responder is busy.
        @(posedge clk); #1;
        MemWrite = 1'b1; Op = SW; Addr = 32'h24; WData = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("midrst_stall", 32'(Stall), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0; MemWrite = 1'b0;
        model_clear();
        @(negedge clk);
        check("midrst_idle_stall", 32'(Stall), 32'd0);
        check("midrst_rdata", RData, 32'h0);
        check("midrst_err", 32'(AddrErr), 32'd0);
        access(0, 1, LW, 32'h24, 32'h0, "lw24");
        check("lw24_const", RData, 32'h0);

        access(1, 0, SH, 32'h42, 32'h0000_BEEF, "sh42");
        access(0, 1, LW, 32'h40, 32'h0, "lw40");
        check("sh42_const", RData, 32'hBEEF_0000);

        for (int n = 0; n < 80; n++) begin
            logic        w, r;
            logic [5:0]  op;
            logic [31:0] a;
            w  = 1'($urandom);
            r  = w ? 1'($urandom) : 1'b1;
            op = ($urandom_range(0, 9) >= 8) ? 6'($urandom) : ops[$urandom_range(0, 7)];
            case ($urandom_range(0, 5))
                0:       a = $urandom;
                1:       a = 32'(DEPTH * 4) - 32'd4 + 32'($urandom_range(0, 7));
                default: a = 32'($urandom_range(0, 63));
            endcase
            access(w, r, op, a, $urandom, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
